// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core RAM port arbiter: requester identifiers and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Which requester owns the RAM this cycle, or which one a read return belongs to
    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_CPU  = 2'd1,
        MEM_VID  = 2'd2,
        MEM_SS   = 2'd3
    } mem_client_t;

    localparam int STARVE_LIMIT_DEF = 16;
    localparam int ADDR_W_DEF       = 12;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Wait-time monitor for one secondary requester; flags when it has waited LIMIT cycles.
// Latency: starved reflects the count registered at the previous edge.
// Backpressure: none; status only, it never influences the grant.
module starve_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ack,
    output logic starved
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    // Count waiting cycles, saturate at the limit, clear when served or withdrawn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (ack || !req) begin
            r_cnt <= '0;
        end else if (r_cnt != LIM) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign starved = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU absolute priority, video/savestate round-robin on idle cycles.
// Latency: grant/ack combinational in the request cycle; read data and valid one cycle later.
// Backpressure: secondaries hold req until a one-cycle ack; the CPU is never stalled.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_halted,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wdata,
    output logic [3:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [3:0]        vid_rdata,
    output logic              vid_valid,
    input  logic              ss_req,
    input  logic              ss_we,
    input  logic [ADDR_W-1:0] ss_addr,
    input  logic [3:0]        ss_wdata,
    output logic              ss_ack,
    output logic [3:0]        ss_rdata,
    output logic              ss_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_wdata,
    input  logic [3:0]        ram_rdata,
    output logic              vid_starved,
    output logic              ss_starved
);
    logic        r_rr_last;   // 0 = video granted last, 1 = savestate granted last
    mem_client_t r_ret_client;
    mem_client_t w_gnt;
    logic        w_vid_cand;
    logic        w_ss_cand;
    logic        w_ss_req_live;

    assign w_vid_cand    = vid_req;
    assign w_ss_req_live = ss_req & cpu_halted;
    assign w_ss_cand     = w_ss_req_live;

    // Pick this cycle's owner; reset forces idle so the RAM sees nothing mid-reset
    always_comb begin
        w_gnt = MEM_NONE;
        if (!reset) begin
            if (cpu_req) begin
                w_gnt = MEM_CPU;
            end else if (w_vid_cand && w_ss_cand) begin
                w_gnt = r_rr_last ? MEM_VID : MEM_SS;
            end else if (w_vid_cand) begin
                w_gnt = MEM_VID;
            end else if (w_ss_cand) begin
                w_gnt = MEM_SS;
            end
        end
    end

    // Steer the winner onto the RAM port and raise its ack
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 4'h0;
        vid_ack   = 1'b0;
        ss_ack    = 1'b0;
        case (w_gnt)
            MEM_CPU: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
            MEM_VID: begin
                ram_addr = vid_addr;
                vid_ack  = 1'b1;
            end
            MEM_SS: begin
                ram_addr  = ss_addr;
                ram_we    = ss_we;
                ram_wdata = ss_wdata;
                ss_ack    = 1'b1;
            end
            default: ;
        endcase
    end

    // Round-robin pointer moves only when a secondary wins; remember who owns the next read return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last    <= 1'b1;
            r_ret_client <= MEM_NONE;
        end else begin
            if (w_gnt == MEM_VID) r_rr_last <= 1'b0;
            else if (w_gnt == MEM_SS) r_rr_last <= 1'b1;
            r_ret_client <= (w_gnt != MEM_NONE && !ram_we) ? w_gnt : MEM_NONE;
        end
    end

    assign cpu_rdata = ram_rdata;
    assign vid_rdata = ram_rdata;
    assign ss_rdata  = ram_rdata;
    assign vid_valid = (r_ret_client == MEM_VID);
    assign ss_valid  = (r_ret_client == MEM_SS);

    // Savestate only waits "for real" while the CPU is halted; otherwise its counter stays clear
    starve_counter #(.LIMIT(STARVE_LIMIT)) u_vid_starve (
        .clk     (clk),
        .reset   (reset),
        .req     (vid_req),
        .ack     (vid_ack),
        .starved (vid_starved)
    );

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_ss_starve (
        .clk     (clk),
        .reset   (reset),
        .req     (w_ss_req_live),
        .ack     (ss_ack),
        .starved (ss_starved)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-derived constants per step.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_halted, cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [3:0]  cpu_wdata, cpu_rdata;
    logic        vid_req, vid_ack, vid_valid;
    logic [11:0] vid_addr;
    logic [3:0]  vid_rdata;
    logic        ss_req, ss_we, ss_ack, ss_valid;
    logic [11:0] ss_addr;
    logic [3:0]  ss_wdata, ss_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata, ram_rdata;
    logic        vid_starved, ss_starved;

    logic [3:0]  mem [4096];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(16), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .cpu_halted(cpu_halted),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_valid(vid_valid),
        .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
        .ss_ack(ss_ack), .ss_rdata(ss_rdata), .ss_valid(ss_valid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .vid_starved(vid_starved), .ss_starved(ss_starved)
    );

    // Synchronous single-port RAM model
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0;
        ss_req = 0; ss_we = 0; ss_addr = 0; ss_wdata = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        to_pos();
        reset = 1'b0;
    endtask

    // ack/valid flag tuple {vid_ack, ss_ack, vid_valid, ss_valid} for the round-robin table
    logic [3:0] rr_exp [5];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
        mem[12'h0A5] = 4'h3;
        mem[12'h200] = 4'hC;
        mem[12'h201] = 4'h9;
        mem[12'h300] = 4'h6;
        mem[12'h010] = 4'h1;
        mem[12'h011] = 4'h2;
        mem[12'h012] = 4'h4;
        rr_exp[0] = 4'b1000;
        rr_exp[1] = 4'b0110;
        rr_exp[2] = 4'b1001;
        rr_exp[3] = 4'b0110;
        rr_exp[4] = 4'b0001;

        // Reset state
        reset = 1'b1; cpu_halted = 1'b0;
        idle_inputs();
        to_neg();
        chk("rst_outputs", {vid_ack, ss_ack, vid_valid, ss_valid, vid_starved, ss_starved, ram_we}, 0);
        chk("rst_ram", {ram_addr, ram_wdata}, 0);
        to_pos();
        reset = 1'b0;

        // 1: CPU read blocks video, then video gets the freed cycle
        cpu_req = 1; cpu_addr = 12'h0A5; vid_req = 1; vid_addr = 12'h200;
        to_neg();
        chk("t1_cpu_addr", ram_addr, 12'h0A5);
        chk("t1_vid_blocked", vid_ack, 0);
        to_pos();
        cpu_req = 0;
        to_neg();
        chk("t1_vid_ack", vid_ack, 1);
        chk("t1_vid_addr", ram_addr, 12'h200);
        chk("t1_cpu_rdata", cpu_rdata, 4'h3);
        to_pos();
        vid_req = 0;
        to_neg();
        chk("t1_vid_valid", vid_valid, 1);
        chk("t1_vid_rdata", vid_rdata, 4'hC);
        chk("t1_no_ack", vid_ack, 0);

        // 2: round-robin after reset starts with video
        to_pos();
        pulse_reset();
        cpu_halted = 1; vid_req = 1; vid_addr = 12'h200;
        ss_req = 1; ss_we = 0; ss_addr = 12'h300;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin vid_req = 0; ss_req = 0; end
            to_neg();
            chk($sformatf("t2_flags_c%0d", c), {vid_ack, ss_ack, vid_valid, ss_valid}, rr_exp[c]);
            if (c == 1) chk("t2_vid_rdata", vid_rdata, 4'hC);
            if (c == 2) chk("t2_ss_rdata", ss_rdata, 4'h6);
            to_pos();
        end

        // 3: savestate write waits while the CPU runs, lands on the first halted idle cycle
        cpu_halted = 0; ss_req = 1; ss_we = 1; ss_addr = 12'h123; ss_wdata = 4'h7;
        for (int c = 0; c < 5; c++) begin
            to_neg();
            chk($sformatf("t3_wait_c%0d", c), {ss_ack, ram_we, ss_starved}, 0);
            to_pos();
        end
        cpu_halted = 1;
        to_neg();
        chk("t3_ack", {ss_ack, ram_we}, 2'b11);
        chk("t3_addr", ram_addr, 12'h123);
        chk("t3_wdata", ram_wdata, 4'h7);
        to_pos();
        ss_req = 0; ss_we = 0; cpu_halted = 0;
        to_neg();
        chk("t3_no_valid", ss_valid, 0);
        to_pos();
        cpu_req = 1; cpu_addr = 12'h123;
        to_pos();
        cpu_req = 0;
        to_neg();
        chk("t3_readback", cpu_rdata, 4'h7);
        to_pos();

        // 4: video starvation under continuous CPU traffic
        cpu_req = 1; cpu_addr = 12'h000; vid_req = 1; vid_addr = 12'h201;
        for (int c = 0; c < 20; c++) begin
            to_neg();
            chk($sformatf("t4_starve_c%0d", c), {vid_ack, vid_starved}, {1'b0, (c >= 16)});
            to_pos();
        end
        cpu_req = 0;
        to_neg();
        chk("t4_ack_starved", {vid_ack, vid_starved}, 2'b11);
        to_pos();
        vid_req = 0;
        to_neg();
        chk("t4_cleared", vid_starved, 0);
        chk("t4_rdata", {vid_valid, vid_rdata}, {1'b1, 4'h9});
        to_pos();

        // 5: reset right after a video ack
        vid_req = 1; vid_addr = 12'h200;
        to_neg();
        chk("t5_pre_ack", vid_ack, 1);
        to_pos();
        reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 12'h0A5; cpu_wdata = 4'hF;
        ss_req = 1; ss_addr = 12'h300; cpu_halted = 1;
        to_neg();
        chk("t5_in_reset", {vid_ack, ss_ack, vid_valid, ss_valid, vid_starved, ss_starved, ram_we}, 0);
        chk("t5_ram_zero", {ram_addr, ram_wdata}, 0);
        to_pos();
        reset = 0; cpu_req = 0; cpu_we = 0; cpu_wdata = 0; vid_addr = 12'h201;
        to_neg();
        chk("t5_tie_vid", {vid_ack, ss_ack, vid_valid}, 3'b100);
        to_pos();
        vid_req = 0; ss_req = 0; cpu_halted = 0; cpu_req = 1; cpu_addr = 12'h0A5;
        to_neg();
        chk("t5_vid_ret", {vid_valid, vid_rdata}, {1'b1, 4'h9});
        to_pos();
        cpu_req = 0;
        to_neg();
        chk("t5_no_write", cpu_rdata, 4'h3);
        to_pos();

        // 6: back-to-back video reads with changing addresses
        vid_req = 1; vid_addr = 12'h010;
        to_neg();
        chk("t6_c0", {vid_ack, vid_valid, ram_addr}, {2'b10, 12'h010});
        to_pos();
        vid_addr = 12'h011;
        to_neg();
        chk("t6_c1", {vid_ack, vid_valid, ram_addr, vid_rdata}, {2'b11, 12'h011, 4'h1});
        to_pos();
        vid_addr = 12'h012;
        to_neg();
        chk("t6_c2", {vid_ack, vid_valid, ram_addr, vid_rdata}, {2'b11, 12'h012, 4'h2});
        to_pos();
        vid_req = 0;
        to_neg();
        chk("t6_c3", {vid_ack, vid_valid, vid_rdata}, {2'b01, 4'h4});
        to_pos();
        to_neg();
        chk("t6_c4", vid_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
